// File: rtl/instruction_fetch_if.sv
// Bundle of memory, redirect and decode-side signals for instruction_fetch.
interface instruction_fetch_if;
    logic [31:0] o_IMemAddr;
    logic        o_IMemReqValid;
    logic        i_IMemReqReady;
    logic        i_IMemRespValid;
    logic [31:0] i_IMemRespData;
    logic        i_Redirect;
    logic [31:0] i_RedirectTarget;
    logic [31:0] o_InstructionWord;
    logic [31:0] o_Pc;
    logic        o_Valid;
    logic        i_Ready;
    logic        o_FetchFault;

    modport master (
        output o_IMemAddr, o_IMemReqValid,
        input  i_IMemReqReady, i_IMemRespValid, i_IMemRespData,
        input  i_Redirect, i_RedirectTarget,
        output o_InstructionWord, o_Pc, o_Valid,
        input  i_Ready,
        output o_FetchFault
    );

    modport slave (
        input  o_IMemAddr, o_IMemReqValid,
        output i_IMemReqReady, i_IMemRespValid, i_IMemRespData,
        output i_Redirect, i_RedirectTarget,
        input  o_InstructionWord, o_Pc, o_Valid,
        output i_Ready,
        input  o_FetchFault
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-limited memory requests, in-order {pc, word} output FIFO.
// Define FETCH_MISALIGN_CHECK_EN to fault on misaligned redirect targets.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic                 i_Clock,
    input logic                 i_Reset,
    instruction_fetch_if.master bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;
    localparam logic [SW-1:0] DEPTH_EXT = SW'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] sq_rd_q, sq_rd_d;
    logic [PW-1:0] sq_wr_q, sq_wr_d;
    logic          fault_q, fault_d;
    logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d   [FIFO_DEPTH];
    logic [31:0]   fifo_word_q [FIFO_DEPTH];
    logic [31:0]   fifo_word_d [FIFO_DEPTH];
    logic [31:0]   sq_pc_q     [FIFO_DEPTH];
    logic [31:0]   sq_pc_d     [FIFO_DEPTH];

    logic          pop;
    logic          fire;
    logic          push;
    logic          req_valid;
    logic [SW-1:0] credit_used;

    always_comb begin
        pop         = (occ_q != '0) && bus.i_Ready;
        // Same-cycle pop frees a slot, which sustains one fetch per cycle.
        credit_used = SW'(out_q) + SW'(occ_q) - SW'(pop);
        req_valid   = !i_Reset && !bus.i_Redirect && !fault_q && (credit_used < DEPTH_EXT);
        fire        = req_valid && bus.i_IMemReqReady;
        push        = bus.i_IMemRespValid && !bus.i_Redirect && (drop_q == '0);

        pc_d        = pc_q;
        out_d       = out_q;
        drop_d      = drop_q;
        occ_d       = occ_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        sq_rd_d     = sq_rd_q;
        sq_wr_d     = sq_wr_q;
        fault_d     = fault_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_word_d = fifo_word_q;
        sq_pc_d     = sq_pc_q;

        // The side queue tracks every issued request, including ones later dropped.
        if (fire) begin
            pc_d             = pc_q + 32'd4;
            sq_pc_d[sq_wr_q] = pc_q;
            sq_wr_d          = sq_wr_q + PW'(1);
        end
        if (bus.i_IMemRespValid) begin
            sq_rd_d = sq_rd_q + PW'(1);
        end
        out_d = out_q + CW'(fire) - CW'(bus.i_IMemRespValid);

        if (bus.i_Redirect) begin
            pc_d     = bus.i_RedirectTarget & 32'hFFFF_FFFC;
            occ_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            drop_d   = out_q - CW'(bus.i_IMemRespValid);
`ifdef FETCH_MISALIGN_CHECK_EN
            fault_d  = (bus.i_RedirectTarget[1:0] != 2'b00);
`endif
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = sq_pc_q[sq_rd_q];
                fifo_word_d[wr_ptr_q] = bus.i_IMemRespData;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end else if (bus.i_IMemRespValid) begin
                drop_d = drop_q - CW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            pc_q        <= RESET_PC & 32'hFFFF_FFFC;
            out_q       <= '0;
            drop_q      <= '0;
            occ_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            sq_rd_q     <= '0;
            sq_wr_q     <= '0;
            fault_q     <= 1'b0;
            fifo_pc_q   <= '{default: '0};
            fifo_word_q <= '{default: '0};
            sq_pc_q     <= '{default: '0};
        end else begin
            pc_q        <= pc_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            occ_q       <= occ_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            sq_rd_q     <= sq_rd_d;
            sq_wr_q     <= sq_wr_d;
            fault_q     <= fault_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_word_q <= fifo_word_d;
            sq_pc_q     <= sq_pc_d;
        end
    end

    assign bus.o_IMemAddr        = pc_q;
    assign bus.o_IMemReqValid    = req_valid;
    assign bus.o_Valid           = (occ_q != '0);
    assign bus.o_InstructionWord = fifo_word_q[rd_ptr_q];
    assign bus.o_Pc              = fifo_pc_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_CHECK_EN
    assign bus.o_FetchFault      = fault_q;
`else
    assign bus.o_FetchFault      = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a depth-2 instance with a 1-cycle memory
// model, and a depth-4 instance with hand-driven responses for the flush case.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int unsigned fires2;
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    instruction_fetch_if bus2();
    instruction_fetch_if bus4();

    instruction_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut2 (
        .i_Clock(clk), .i_Reset(rst), .bus(bus2)
    );
    instruction_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4)) dut4 (
        .i_Clock(clk), .i_Reset(rst), .bus(bus4)
    );

    // Single-cycle memory for dut2: word = addr ^ 32'hDEAD_0000.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            bus2.i_IMemRespValid <= 1'b0;
            bus2.i_IMemRespData  <= '0;
        end else begin
            if (bus2.i_IMemRespValid) void'(mq.pop_front());
            if (bus2.o_IMemReqValid && bus2.i_IMemReqReady) mq.push_back(bus2.o_IMemAddr);
            if (mq.size() != 0) begin
                bus2.i_IMemRespValid <= 1'b1;
                bus2.i_IMemRespData  <= mq[0] ^ 32'hDEAD_0000;
            end else begin
                bus2.i_IMemRespValid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) fires2 <= 0;
        else if (bus2.o_IMemReqValid && bus2.i_IMemReqReady) fires2 <= fires2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus2.i_IMemReqReady = 1'b1; bus2.i_Redirect = 1'b0; bus2.i_RedirectTarget = '0; bus2.i_Ready = 1'b1;
        bus4.i_IMemReqReady = 1'b1; bus4.i_Redirect = 1'b0; bus4.i_RedirectTarget = '0; bus4.i_Ready = 1'b0;
        bus4.i_IMemRespValid = 1'b0; bus4.i_IMemRespData = '0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_addr", bus2.o_IMemAddr, 32'h100);
        chk("rst_reqv", bus2.o_IMemReqValid, 0);
        chk("rst_valid", bus2.o_Valid, 0);
        chk("rst_pc", bus2.o_Pc, 0);
        chk("rst_word", bus2.o_InstructionWord, 0);
        chk("rst_fault", bus2.o_FetchFault, 0);

        // Startup and streaming with i_Ready high
        @(negedge clk); rst = 1'b0; #1;
        chk("c0_addr", bus2.o_IMemAddr, 32'h100);
        chk("c0_reqv", bus2.o_IMemReqValid, 1);
        chk("c0_valid", bus2.o_Valid, 0);
        @(negedge clk); #1;
        chk("c1_valid", bus2.o_Valid, 0);
        chk("c1_addr", bus2.o_IMemAddr, 32'h104);
        @(negedge clk); #1;
        chk("c2_valid", bus2.o_Valid, 1);
        chk("c2_pc", bus2.o_Pc, 32'h100);
        chk("c2_word", bus2.o_InstructionWord, 32'hDEAD_0100);
        @(negedge clk); #1;
        chk("c3_pc", bus2.o_Pc, 32'h104);
        chk("c3_word", bus2.o_InstructionWord, 32'hDEAD_0104);

        // Redirect coinciding with a response and a pop
        @(negedge clk); bus2.i_Redirect = 1'b1; bus2.i_RedirectTarget = 32'h3000; #1;
        chk("rd_head_pc", bus2.o_Pc, 32'h108);
        chk("rd_reqv", bus2.o_IMemReqValid, 0);
        @(negedge clk); bus2.i_Redirect = 1'b0; #1;
        chk("rd_flush", bus2.o_Valid, 0);
        chk("rd_addr", bus2.o_IMemAddr, 32'h3000);
        chk("rd_reqv2", bus2.o_IMemReqValid, 1);
        @(negedge clk); #1;
        chk("rd_nopush", bus2.o_Valid, 0);
        @(negedge clk); #1;
        chk("rd_valid", bus2.o_Valid, 1);
        chk("rd_pc", bus2.o_Pc, 32'h3000);
        chk("rd_word", bus2.o_InstructionWord, 32'hDEAD_3000);

        // PC wrap
        @(negedge clk); bus2.i_Redirect = 1'b1; bus2.i_RedirectTarget = 32'hFFFF_FFFC; #1;
        chk("wr_head", bus2.o_Pc, 32'h3004);
        @(negedge clk); bus2.i_Redirect = 1'b0; #1;
        chk("wr_addr0", bus2.o_IMemAddr, 32'hFFFF_FFFC);
        chk("wr_reqv0", bus2.o_IMemReqValid, 1);
        chk("wr_valid0", bus2.o_Valid, 0);
        @(negedge clk); #1;
        chk("wr_addr1", bus2.o_IMemAddr, 32'h0);
        chk("wr_reqv1", bus2.o_IMemReqValid, 1);
        @(negedge clk); #1;
        chk("wr_pc0", bus2.o_Pc, 32'hFFFF_FFFC);
        chk("wr_word0", bus2.o_InstructionWord, 32'h2152_FFFC);

        // Misaligned redirect
        @(negedge clk); bus2.i_Redirect = 1'b1; bus2.i_RedirectTarget = 32'h2002; #1;
        chk("wr_pc1", bus2.o_Pc, 32'h0);
        chk("wr_word1", bus2.o_InstructionWord, 32'hDEAD_0000);
        @(negedge clk); bus2.i_Redirect = 1'b0; #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_fault", bus2.o_FetchFault, 1);
        chk("mis_reqv", bus2.o_IMemReqValid, 0);
        chk("mis_valid", bus2.o_Valid, 0);
        @(negedge clk); bus2.i_Redirect = 1'b1; bus2.i_RedirectTarget = 32'h3000; #1;
        chk("mis_fault_hold", bus2.o_FetchFault, 1);
        chk("mis_reqv_hold", bus2.o_IMemReqValid, 0);
        @(negedge clk); bus2.i_Redirect = 1'b0; #1;
        chk("mis_clear", bus2.o_FetchFault, 0);
        chk("mis_addr", bus2.o_IMemAddr, 32'h3000);
        chk("mis_reqv2", bus2.o_IMemReqValid, 1);
        @(negedge clk);
        @(negedge clk); #1;
        chk("mis_pc", bus2.o_Pc, 32'h3000);
        chk("mis_word", bus2.o_InstructionWord, 32'hDEAD_3000);
`else
        chk("mis_addr", bus2.o_IMemAddr, 32'h2000);
        chk("mis_reqv", bus2.o_IMemReqValid, 1);
        chk("mis_fault", bus2.o_FetchFault, 0);
        @(negedge clk);
        @(negedge clk); #1;
        chk("mis_pc", bus2.o_Pc, 32'h2000);
        chk("mis_word", bus2.o_InstructionWord, 32'hDEAD_2000);
`endif

        // Mid-operation reset, then stall on dut2 while dut4 flushes
        @(negedge clk); rst = 1'b1; bus2.i_Ready = 1'b0;
        @(negedge clk); #1;
        chk("rst2_valid", bus2.o_Valid, 0);
        chk("rst2_reqv", bus2.o_IMemReqValid, 0);
        chk("rst2_addr", bus2.o_IMemAddr, 32'h100);
        chk("rst2_fault", bus2.o_FetchFault, 0);
        chk("rst2_v4", bus4.o_Valid, 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("s0_addr", bus2.o_IMemAddr, 32'h100);
        chk("f0_addr", bus4.o_IMemAddr, 32'h100);
        @(negedge clk); bus4.i_IMemRespValid = 1'b1; bus4.i_IMemRespData = 32'hDEAD_0100; #1;
        chk("f1_addr", bus4.o_IMemAddr, 32'h104);
        @(negedge clk); bus4.i_IMemRespValid = 1'b0; #1;
        chk("s2_pc", bus2.o_Pc, 32'h100);
        chk("f2_addr", bus4.o_IMemAddr, 32'h108);
        chk("f2_reqv", bus4.o_IMemReqValid, 1);
        @(negedge clk); bus4.i_Redirect = 1'b1; bus4.i_RedirectTarget = 32'h2000; #1;
        chk("f3_valid", bus4.o_Valid, 1);
        chk("f3_reqv", bus4.o_IMemReqValid, 0);
        @(negedge clk); bus4.i_Redirect = 1'b0;
        bus4.i_IMemRespValid = 1'b1; bus4.i_IMemRespData = 32'hDEAD_0104; #1;
        chk("f4_flush", bus4.o_Valid, 0);
        chk("f4_addr", bus4.o_IMemAddr, 32'h2000);
        chk("f4_reqv", bus4.o_IMemReqValid, 1);
        @(negedge clk); bus4.i_IMemRespData = 32'hDEAD_0108; #1;
        chk("f5_drop1", bus4.o_Valid, 0);
        chk("s5_fires", fires2, 2);
        chk("s5_reqv", bus2.o_IMemReqValid, 0);
        chk("s5_valid", bus2.o_Valid, 1);
        chk("s5_pc", bus2.o_Pc, 32'h100);
        @(negedge clk); bus4.i_IMemRespData = 32'hDEAD_2000; bus2.i_Ready = 1'b1; #1;
        chk("f6_drop2", bus4.o_Valid, 0);
        chk("s6_pc", bus2.o_Pc, 32'h100);
        chk("s6_reqv", bus2.o_IMemReqValid, 1);
        chk("s6_addr", bus2.o_IMemAddr, 32'h108);
        @(negedge clk); bus4.i_IMemRespValid = 1'b0; #1;
        chk("f7_valid", bus4.o_Valid, 1);
        chk("f7_pc", bus4.o_Pc, 32'h2000);
        chk("f7_word", bus4.o_InstructionWord, 32'hDEAD_2000);
        chk("s7_pc", bus2.o_Pc, 32'h104);
        chk("s7_word", bus2.o_InstructionWord, 32'hDEAD_0104);
        @(negedge clk); #1;
        chk("s8_pc", bus2.o_Pc, 32'h108);
        chk("s8_word", bus2.o_InstructionWord, 32'hDEAD_0108);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
